// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with IDLE/LOAD/RUN/FLUSH control and a Mealy detect output.
// Define SEQ_DETECT_CTRL_COUNT_EN to build the saturating detection counter.
module seq_detect_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [4:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    output logic               out,
    output logic               busy,
    output logic [1:0]         currentstate,
    output logic [CNT_W-1:0]   det_count,
    output logic               count_sat
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] RUN   = 2'b10;
    localparam logic [1:0] FLUSH = 2'b11;
    localparam logic [4:0] LEN_MAX = 5'(PAT_MAX);

    logic [1:0]         state_q, state_d;
    logic               configured_q, configured_d;
    logic [PAT_MAX-1:0] pattern_q, pattern_d;
    logic [4:0]         len_q, len_d;
    logic               overlap_q, overlap_d;
    // The current bit always completes a match, so only PAT_MAX-1 older bits are kept.
    logic [PAT_MAX-2:0] hist_q, hist_d;
    logic [4:0]         fill_q, fill_d;

    logic [4:0]         len_clamped;
    logic [4:0]         fill_inc;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] len_mask;
    logic               match;
    logic               start_run;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == 5'd0) begin
            len_clamped = 5'd1;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign window    = {hist_q, in};
    assign fill_inc  = fill_q + 5'd1;
    assign match     = (((window ^ pattern_q) & len_mask) == '0);
    assign start_run = (state_q == IDLE) && !cfg_valid && configured_q && start && !stop;

    always_comb begin
        state_d      = state_q;
        configured_d = configured_q;
        pattern_d    = pattern_q;
        len_d        = len_q;
        overlap_d    = overlap_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        out          = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d   = LOAD;
                    pattern_d = cfg_pattern;
                    len_d     = len_clamped;
                    overlap_d = cfg_overlap;
                end else if (start_run) begin
                    state_d = RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            LOAD: begin
                configured_d = 1'b1;
                state_d      = IDLE;
            end
            RUN: begin
                if (stop) begin
                    state_d = FLUSH;
                    hist_d  = '0;
                    fill_d  = '0;
                end else if (in_valid) begin
                    hist_d = window[PAT_MAX-2:0];
                    if ((fill_inc >= len_q) && match) begin
                        out    = 1'b1;
                        fill_d = overlap_q ? len_q : 5'd0;
                    end else begin
                        fill_d = (fill_inc >= len_q) ? len_q : fill_inc;
                    end
                end
            end
            FLUSH: begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            configured_q <= 1'b0;
            pattern_q    <= '0;
            len_q        <= '0;
            overlap_q    <= 1'b0;
            hist_q       <= '0;
            fill_q       <= '0;
        end else begin
            state_q      <= state_d;
            configured_q <= configured_d;
            pattern_q    <= pattern_d;
            len_q        <= len_d;
            overlap_q    <= overlap_d;
            hist_q       <= hist_d;
            fill_q       <= fill_d;
        end
    end

    assign cfg_ready    = (state_q == IDLE);
    assign busy         = state_q[1];
    assign currentstate = state_q;

`ifdef SEQ_DETECT_CTRL_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] det_count_q;
    logic             count_sat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_count_q <= '0;
            count_sat_q <= 1'b0;
        end else if (start_run) begin
            det_count_q <= '0;
            count_sat_q <= 1'b0;
        end else if (out && (det_count_q != CNT_MAX)) begin
            det_count_q <= det_count_q + 1'b1;
            if (det_count_q == CNT_MAX - 1'b1) begin
                count_sat_q <= 1'b1;
            end
        end
    end

    assign det_count = det_count_q;
    assign count_sat = count_sat_q;
`else
    assign det_count = '0;
    assign count_sat = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Randomized self-checking bench for seq_detect_ctrl against a queue-based pattern model.
module tb_seq_detect_ctrl;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;
`ifdef SEQ_DETECT_CTRL_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [4:0]         cfg_len;
    logic               cfg_overlap;
    logic               start;
    logic               stop;
    logic               in_b;
    logic               in_valid;
    logic               out_b;
    logic               busy;
    logic [1:0]         currentstate;
    logic [CNT_W-1:0]   det_count;
    logic               count_sat;

    int total = 0;
    int bad   = 0;

    logic [PAT_MAX-1:0] m_pat;
    int                 m_len;
    bit                 m_ov;
    bit                 seen[$];
    int                 m_cnt;

    seq_detect_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .start(start), .stop(stop), .in(in_b), .in_valid(in_valid),
        .out(out_b), .busy(busy), .currentstate(currentstate),
        .det_count(det_count), .count_sat(count_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > PAT_MAX) return PAT_MAX;
        return l;
    endfunction

    // Keeps the last m_len accepted bits; a hit is when they spell the pattern (bit 0 newest).
    function automatic bit model_bit(input bit b);
        bit hit;
        seen.push_back(b);
        if (seen.size() > m_len) void'(seen.pop_front());
        hit = (seen.size() == m_len);
        for (int i = 0; i < m_len && hit; i++) begin
            if (seen[m_len - 1 - i] != m_pat[i]) hit = 1'b0;
        end
        if (hit) begin
            if (!m_ov) seen.delete();
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        return hit;
    endfunction

    task automatic check_state(input string name, input logic [1:0] exp);
        total++;
        if (currentstate !== exp) begin
            bad++;
            $display("FAIL %s: state got %b expected %b", name, currentstate, exp);
        end
    endtask

    task automatic check_count(input string name);
        int exp_cnt;
        bit exp_sat;
        exp_cnt = COUNT_EN ? m_cnt : 0;
        exp_sat = COUNT_EN ? (m_cnt == CNT_MAX) : 1'b0;
        total++;
        if (det_count !== CNT_W'(exp_cnt) || count_sat !== exp_sat) begin
            bad++;
            $display("FAIL %s: det_count/sat got %0d/%b expected %0d/%b",
                     name, det_count, count_sat, exp_cnt, exp_sat);
        end
    endtask

    task automatic do_cfg(input logic [PAT_MAX-1:0] p, input int l, input bit ov);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = 5'(l); cfg_overlap = ov;
        tick();
        cfg_valid = 1'b0;
        check_state("cfg_load", 2'b01);
        tick();
        check_state("cfg_back_idle", 2'b00);
        m_pat = p; m_len = clamp_len(l); m_ov = ov;
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen.delete();
        m_cnt = 0;
        check_state("arm_run", 2'b10);
    endtask

    task automatic feed(input bit b, input string name);
        bit exp;
        in_b = b; in_valid = 1'b1;
        #1;
        exp = model_bit(b);
        total++;
        if (out_b !== exp) begin
            bad++;
            $display("FAIL %s: out got %b expected %b", name, out_b, exp);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0; in_b = $urandom_range(0, 1);
        #1;
        total++;
        if (out_b !== 1'b0) begin
            bad++;
            $display("FAIL idle_out: out got %b expected 0", out_b);
        end
        tick();
    endtask

    task automatic halt();
        stop = 1'b1; in_valid = 1'b1; in_b = 1'b1;
        #1;
        total++;
        if (out_b !== 1'b0) begin
            bad++;
            $display("FAIL stop_out: out got %b expected 0", out_b);
        end
        tick();
        stop = 1'b0; in_valid = 1'b0;
        check_state("flush", 2'b11);
        tick();
        check_state("flush_to_idle", 2'b00);
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_flags: busy/cfg_ready got %b/%b expected 0/1", busy, cfg_ready);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        m_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset_state", 2'b00);
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || out_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: busy/cfg_ready/out got %b/%b/%b expected 0/1/0",
                     busy, cfg_ready, out_b);
        end
        check_count("reset_count");
    endtask

    task automatic test_nonoverlap();
        bit seq[7] = '{1, 0, 0, 1, 0, 0, 1};
        do_cfg(8'b1001, 4, 1'b0);
        arm();
        foreach (seq[i]) feed(seq[i], "nonoverlap_out");
        total++;
        if (det_count !== CNT_W'(COUNT_EN ? 1 : 0)) begin
            bad++;
            $display("FAIL nonoverlap_count: got %0d expected %0d", det_count, COUNT_EN ? 1 : 0);
        end
        halt();
    endtask

    task automatic test_overlap();
        bit seq[7] = '{1, 0, 0, 1, 0, 0, 1};
        do_cfg(8'b1001, 4, 1'b1);
        arm();
        foreach (seq[i]) feed(seq[i], "overlap_out");
        total++;
        if (det_count !== CNT_W'(COUNT_EN ? 2 : 0)) begin
            bad++;
            $display("FAIL overlap_count: got %0d expected %0d", det_count, COUNT_EN ? 2 : 0);
        end
        halt();
    endtask

    task automatic test_no_config();
        do_reset();
        start = 1'b1;
        tick();
        check_state("noconfig_state", 2'b00);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL noconfig_busy: got %b expected 0", busy);
        end
        tick();
        start = 1'b0;
        check_state("noconfig_state2", 2'b00);
    endtask

    task automatic test_cfg_during_run();
        do_cfg(8'b11, 2, 1'b0);
        arm();
        feed(1'b1, "cfgrun_out0");
        cfg_valid = 1'b1; cfg_pattern = 8'b00; cfg_len = 5'd2; cfg_overlap = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL cfgrun_ready: got %b expected 0", cfg_ready);
        end
        feed(1'b1, "cfgrun_out1");
        feed(1'b0, "cfgrun_out2");
        feed(1'b0, "cfgrun_out3");
        feed(1'b1, "cfgrun_out4");
        feed(1'b1, "cfgrun_out5");
        check_state("cfgrun_still_run", 2'b10);
        cfg_valid = 1'b0;
        halt();
    endtask

    task automatic test_saturation();
        do_cfg(8'h01, 1, 1'b0);
        arm();
        for (int i = 0; i < 5; i++) feed(1'b1, "sat_out");
        total++;
        if (det_count !== CNT_W'(COUNT_EN ? 3 : 0) || count_sat !== COUNT_EN) begin
            bad++;
            $display("FAIL sat_count: det_count/sat got %0d/%b expected %0d/%b",
                     det_count, count_sat, COUNT_EN ? 3 : 0, COUNT_EN);
        end
        halt();
        check_count("sat_hold_after_stop");
    endtask

    task automatic test_reset_mid_run();
        do_cfg(8'b1001, 4, 1'b0);
        arm();
        feed(1'b1, "rst_out0");
        feed(1'b0, "rst_out1");
        feed(1'b0, "rst_out2");
        in_b = 1'b1; in_valid = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check_state("rst_async_state", 2'b00);
        total++;
        if (out_b !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_async_out: out/busy got %b/%b expected 0/0", out_b, busy);
        end
        tick();
        total++;
        if (out_b !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold_out: got %b expected 0", out_b);
        end
        in_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        m_cnt = 0;
        check_count("rst_count");
        start = 1'b1;
        tick();
        start = 1'b0;
        check_state("rst_unconfigured", 2'b00);
    endtask

    task automatic test_random();
        for (int r = 0; r < 14; r++) begin
            logic [PAT_MAX-1:0] p;
            int l;
            int idx;
            bit b;
            p = PAT_MAX'($urandom);
            l = (r % 4 == 3) ? $urandom_range(0, 20) : $urandom_range(0, 4);
            do_cfg(p, l, 1'(r % 2));
            arm();
            idx = clamp_len(l) - 1;
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle_cycle();
                end else begin
                    b = p[idx];
                    if ($urandom_range(0, 5) == 0) b = ~b;
                    idx = (idx == 0) ? clamp_len(l) - 1 : idx - 1;
                    feed(b, "rand_out");
                end
            end
            check_count("rand_count");
            halt();
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        start = 1'b0; stop = 1'b0; in_b = 1'b0; in_valid = 1'b0;
        m_pat = '0; m_len = 1; m_ov = 1'b0; m_cnt = 0;
        test_reset();
        test_nonoverlap();
        test_overlap();
        test_no_config();
        test_cfg_during_run();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_MAX, default 8: maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8: detection counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  configuration accept; high only in IDLE.
REQ-007 SHALL have port cfg_pattern  input  PAT_MAX  target sequence; bit 0 is the last-arriving bit.
REQ-008 SHALL have port cfg_len  input  5  pattern length.
REQ-009 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port start  input  1  arm detection.
REQ-011 SHALL have port stop  input  1  disarm detection.
REQ-012 SHALL have port in  input  1  serial data bit.
REQ-013 SHALL have port in_valid  input  1  qualifies in.
REQ-014 SHALL have port out  output  1  detection pulse (Mealy).
REQ-015 SHALL have port busy  output  1  high in RUN or FLUSH.
REQ-016 SHALL have port currentstate  output  2  FSM state encoding.
REQ-017 SHALL have port det_count  output  CNT_W  detections since last start.
REQ-018 SHALL have port count_sat  output  1  det_count has saturated.

Function
REQ-019 SHALL implement states IDLE=2'b00, LOAD=2'b01, RUN=2'b10, FLUSH=2'b11.
REQ-020 SHALL, in IDLE, on cfg_valid&cfg_ready, latch pattern/len/overlap, enter LOAD for exactly one cycle, set configured flag, then return to IDLE.
REQ-021 SHALL clamp cfg_len: 0 -> 1, >PAT_MAX -> PAT_MAX.
REQ-022 SHALL, in IDLE with configured=1 and start=1 and stop=0, enter RUN, clear history, fill count and det_count.
REQ-023 SHALL ignore start when configured=0 or when not in IDLE; stop wins over a simultaneous start.
REQ-024 SHALL, in RUN with in_valid=1 and stop=0, shift in into a PAT_MAX-bit history and increment fill count (saturating at len).
REQ-025 SHALL assert out combinationally in the same cycle as the completing bit when RUN, in_valid=1, stop=0, fill count (including current bit) >= len, and low len bits of {history, in} equal low len bits of the pattern.
REQ-026 SHALL, on detection with overlap=0, reset fill count to 0; with overlap=1, keep fill at len.
REQ-027 SHALL hold history and fill unchanged on in_valid=0; out SHALL be 0.
REQ-028 SHALL, in RUN on stop=1, not sample in, force out=0, enter FLUSH for one cycle (clearing history/fill), then IDLE.
REQ-029 SHALL keep cfg_ready=0 outside IDLE; configuration offers then are not consumed.
REQ-030 SHALL increment det_count on each out pulse, saturating at 2^CNT_W-1 and setting count_sat; det_count holds after stop until next start.

Reset
REQ-031 SHALL, on reset_n low, immediately set state IDLE, configured=0, pattern/len/overlap=0, history/fill=0, det_count=0, count_sat=0, out=0, busy=0, cfg_ready=1 after release.
REQ-032 SHALL, on reset mid-RUN, abandon the run with no out pulse during or after reset.

Configuration
REQ-033 SHALL compile the detection counter only when macro SEQ_DETECT_CTRL_COUNT_EN is defined; otherwise det_count and count_sat SHALL be tied to 0, all other behaviour unchanged.

Verification
REQ-034 SHALL check: load 1001, len 4, overlap=0, start, feed 1001001 -> out high on bit 4 only, det_count=1.
REQ-035 SHALL check: same with overlap=1 -> out high on bits 4 and 7, det_count=2.
REQ-036 SHALL check: start without prior config -> state stays 2'b00, busy=0.
REQ-037 SHALL check: cfg_valid during RUN -> cfg_ready=0, pattern unchanged; stop -> FLUSH one cycle then IDLE.
REQ-038 SHALL check: CNT_W=2, pattern 1, len 1, feed 5 ones -> det_count=3, count_sat=1 (macro defined); det_count=0 when undefined.
REQ-039 SHALL check: reset_n low mid-RUN after 100 -> state 2'b00 asynchronously, out=0, configured cleared.
